servo_pwm_bank: RTL
===================

Name: servo_pwm_bank

Overview:
- Parametrised register bank plus PWM generator for N servo channels, addressed over a simple write/read bus from the controller.
- Replaces the one-hot selector scheme with a binary channel/field address.
- Adds double-buffered (staged/active) per-channel registers, period-synchronous update, readback and status.
- Drives the servo PWM pins and direction lines directly.

Parameters:
- N_CH, 8, number of servo channels (1..16).
- DW, 32, width of pulse-width registers and of the period counter.
- PERIOD, 1000000, PWM period in clk cycles (20 ms at 50 MHz); must be ≥2.
- SYNC_UPDATE, 1: staged→active copy happens only at period wrap. 0: copy happens on the cycle after each write.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  bus select.
- wr  in  1  1 = write, 0 = read (qualified by cs).
- addr  in  AW=$clog2(N_CH)+2  {channel, field}; field is addr[1:0].
- d_in  in  DW  write data.
- rd_data  out  DW  read data.
- pwm_out  out  N_CH  servo PWM outputs.
- dir_out  out  N_CH  per-channel direction lines.
- period_start  out  1  one-cycle pulse at each period wrap.

Behaviour:
- Reset (async assert, sync release): all outputs, counter and staged/active registers are 0.
- Field map per channel:
  - 0 CTRL: bit0 enable, bit1 dir; upper bits write-ignored, read 0.
  - 1 WIDTH: pulse width in clk cycles, DW bits.
  - 2 STATUS: read-only. bit0 = pending (staged ≠ active for CTRL or WIDTH); bit1 = active enable.
  - 3: reserved.
- Write (cs & wr):
  - Updates staged CTRL/WIDTH of channel addr[AW-1:2] at the rising edge.
  - Ignored if channel ≥ N_CH, field 2 or field 3.
- Read (cs & ~wr):
  - rd_data is registered and valid 1 cycle after the request.
  - Returns the staged value for CTRL and WIDTH, and live status for STATUS.
  - Invalid addresses return 0.
  - rd_data holds its last value when no read is requested.
- Period counter cnt:
  - Counts 0..PERIOD-1 and wraps to 0.
  - Free-running out of reset.
- Wrap cycle is the cycle where cnt == PERIOD-1. On that cycle:
  - period_start is registered high on the next cycle, coincident with cnt == 0.
  - If SYNC_UPDATE=1, every channel copies staged→active at that edge.
- Simultaneous write and wrap on the same edge: the copy uses the pre-write staged value. The new value takes effect at the following wrap, and pending reads 1 afterwards.
- SYNC_UPDATE=0: the staged→active copy happens on the edge after the write edge, so pending is high for exactly 1 cycle.
- pwm_out[i] is registered and equals active_en[i] & (cnt < active_width[i]), using the cnt of the previous cycle.
  - Width 0 → constant low.
  - Width ≥ PERIOD → constant high while enabled.
- dir_out[i] equals active dir, registered. It changes only when active changes.
- Disabling a channel takes effect at the next active copy, never mid-pulse when SYNC_UPDATE=1.
- Reset mid-period: outputs drop to 0 immediately. Counting restarts from 0 after release.
- No combinational path from bus inputs to any output.

Decomposition:
- Package servo_pkg holds:
  - field codes FLD_CTRL=0, FLD_WIDTH=1, FLD_STATUS=2;
  - CTRL bit positions CTRL_EN=0, CTRL_DIR=1;
  - STATUS bit positions.
- Sub-module servo_channel (instantiated N_CH times) holds:
  - staged/active registers;
  - the compare and pwm/dir output flops;
  - inputs: write strobes, copy strobe, cnt.
- The top level holds address decode, the period counter, the read mux and period_start.

Test Plan:
- Reset and idle, PERIOD=100, N_CH=8: hold rst_n=0 for 5 cycles, then release. Required: all outputs 0, period_start every 100 cycles, first pulse coincident with cnt==0 of the second period (cycle 100 after release).
- Write and period sync, SYNC_UPDATE=1: write ch3 WIDTH=25, then CTRL=0x3 mid-period. Required:
  - STATUS ch3 reads 0x1 until the wrap;
  - pwm_out[3] high for exactly 25 cycles each period starting 1 cycle after cnt==0;
  - dir_out[3]=1 from the wrap;
  - other channels stay 0.
- Boundary widths: ch0 WIDTH=0 enabled → pwm_out[0] constant 0. ch1 WIDTH=100 and ch2 WIDTH=0xFFFFFFFF, both enabled → pwm_out[1] and pwm_out[2] constant 1.
- Write on wrap cycle: write ch5 WIDTH=40 on the edge where cnt==99. Required: the old width is applied for that period, the new width from the next wrap, and STATUS ch5 bit0=1 during the intervening period.
- Readback and invalid addresses, SYNC_UPDATE=0: write ch7 WIDTH=0x12345678.
  - Read it → 0x12345678 one cycle later.
  - Field 3 reads 0.
  - A write to field 2 has no effect.
  - With N_CH=6, writes to ch6/ch7 are ignored and read 0.
- Mid-operation reset: ch4 enabled with WIDTH=50; assert rst_n at cnt=20. Required: pwm_out, rd_data and period_start go to 0 asynchronously; after release, STATUS ch4 reads 0 and no pulse occurs until reprogrammed.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg
//   Shared definitions for the servo PWM bank: bus field codes, CTRL and
//   STATUS bit positions, the packed CTRL layout and a channel-index width
//   helper.
package servo_pkg;

  // Low two address bits select the per-channel field.
  typedef enum logic [1:0] {
    FLD_CTRL   = 2'd0,
    FLD_WIDTH  = 2'd1,
    FLD_STATUS = 2'd2,
    FLD_RSVD   = 2'd3
  } field_e;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;

  localparam int STAT_PEND = 0;
  localparam int STAT_EN   = 1;

  // Only the two meaningful CTRL bits are stored; bit order matches CTRL_EN/CTRL_DIR.
  typedef struct packed {
    logic dir;
    logic en;
  } ctrl_t;

  // The channel index needs at least one bit even for a single-channel bank.
  function automatic int ch_bits(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// servo_channel
//   One servo channel: staged and active CTRL/WIDTH registers, live status,
//   and the registered PWM/direction outputs.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_wr_ctrl    write strobe for staged CTRL (bits taken from i_d_in)
//   i_wr_width   write strobe for staged WIDTH
//   i_d_in       bus write data
//   i_copy       staged -> active copy strobe
//   i_cnt        current period counter value
//   o_stg_ctrl   staged CTRL {dir, en} for readback
//   o_stg_width  staged WIDTH for readback
//   o_status     {active enable, pending}
//   o_pwm        PWM output
//   o_dir        direction output
module servo_channel
  import servo_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_ctrl,
  input  logic          i_wr_width,
  input  logic [DW-1:0] i_d_in,
  input  logic          i_copy,
  input  logic [DW-1:0] i_cnt,
  output logic [1:0]    o_stg_ctrl,
  output logic [DW-1:0] o_stg_width,
  output logic [1:0]    o_status,
  output logic          o_pwm,
  output logic          o_dir
);

  ctrl_t         r_stg_ctrl;
  ctrl_t         r_act_ctrl;
  logic [DW-1:0] r_stg_width;
  logic [DW-1:0] r_act_width;
  logic          r_pwm;
  logic          w_pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stg_ctrl  <= '0;
      r_stg_width <= '0;
    end else begin
      if (i_wr_ctrl) begin
        r_stg_ctrl.en  <= i_d_in[CTRL_EN];
        r_stg_ctrl.dir <= i_d_in[CTRL_DIR];
      end
      if (i_wr_width) r_stg_width <= i_d_in;
    end
  end

  // A write landing on the same edge as the copy is not seen by the copy:
  // the active side takes the staged value as it was before that edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_act_ctrl  <= '0;
      r_act_width <= '0;
    end else if (i_copy) begin
      r_act_ctrl  <= r_stg_ctrl;
      r_act_width <= r_stg_width;
    end
  end

  // Compare uses this cycle's counter, so the pin lags cnt by one cycle.
  // Width 0 never matches; width >= PERIOD always matches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pwm <= 1'b0;
    else          r_pwm <= r_act_ctrl.en & (i_cnt < r_act_width);
  end

  assign w_pending = (r_stg_ctrl != r_act_ctrl) | (r_stg_width != r_act_width);

  always_comb begin
    o_status            = '0;
    o_status[STAT_PEND] = w_pending;
    o_status[STAT_EN]   = r_act_ctrl.en;
  end

  assign o_stg_ctrl  = r_stg_ctrl;
  assign o_stg_width = r_stg_width;
  assign o_pwm       = r_pwm;
  assign o_dir       = r_act_ctrl.dir;

endmodule

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank
//   Register bank and PWM generator for N_CH servo channels. A binary
//   {channel, field} address selects CTRL, WIDTH or STATUS of a channel.
//   Writes land in staged registers; staged values move to active either at
//   each period wrap (SYNC_UPDATE=1) or on the cycle after a write
//   (SYNC_UPDATE=0). All outputs are registered.
//
// Ports
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_cs            bus select
//   i_wr            1 = write, 0 = read (qualified by i_cs)
//   i_addr          {channel, field[1:0]}
//   i_d_in          write data
//   o_rd_data       registered read data, valid one cycle after the read
//   o_pwm_out       per-channel PWM pins
//   o_dir_out       per-channel direction lines
//   o_period_start  one-cycle pulse coincident with cnt == 0 after a wrap
module servo_pwm_bank
  import servo_pkg::*;
#(
  parameter  int N_CH        = 8,
  parameter  int DW          = 32,
  parameter  int PERIOD      = 1000000,
  parameter  int SYNC_UPDATE = 1,
  localparam int AW          = $clog2(N_CH) + 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cs,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_d_in,
  output logic [DW-1:0] o_rd_data,
  output logic [N_CH-1:0] o_pwm_out,
  output logic [N_CH-1:0] o_dir_out,
  output logic          o_period_start
);

  localparam int            CHW      = ch_bits(N_CH);
  localparam logic [DW-1:0] CNT_LAST = DW'(PERIOD - 1);

  logic [CHW-1:0]  w_ch;
  logic            w_ch_ok;
  field_e          w_fld;
  logic            w_wr;
  logic [N_CH-1:0] w_wr_ctrl;
  logic [N_CH-1:0] w_wr_width;
  logic [N_CH-1:0] w_copy;
  logic            w_wrap;
  logic [DW-1:0]   w_rd_next;

  logic [1:0]      w_stg_ctrl  [N_CH];
  logic [DW-1:0]   w_stg_width [N_CH];
  logic [1:0]      w_status    [N_CH];

  logic [DW-1:0]   r_cnt;
  logic            r_period_start;
  logic [DW-1:0]   r_rd_data;

  // ---------------------------------------------------------------- decode
  generate
    if (AW > 2) begin : g_ch_addr
      assign w_ch = i_addr[AW-1:2];
    end else begin : g_ch_single
      assign w_ch = '0;
    end
  endgenerate

  // Non-power-of-two banks leave the top channel codes unpopulated.
  assign w_ch_ok = ({1'b0, w_ch} < (CHW + 1)'(N_CH));
  assign w_fld   = field_e'(i_addr[1:0]);
  assign w_wr    = i_cs & i_wr & w_ch_ok;

  // -------------------------------------------------------- period counter
  assign w_wrap = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_cnt          <= w_wrap ? '0 : r_cnt + 1'b1;
      r_period_start <= w_wrap;
    end
  end

  // ----------------------------------------------------------- copy strobe
  generate
    if (SYNC_UPDATE != 0) begin : g_sync
      assign w_copy = {N_CH{w_wrap}};
    end else begin : g_async
      logic [N_CH-1:0] r_wr_d;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_wr_d <= '0;
        else          r_wr_d <= w_wr_ctrl | w_wr_width;
      end
      assign w_copy = r_wr_d;
    end
  endgenerate

  // -------------------------------------------------------------- channels
  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign w_wr_ctrl[g]  = w_wr & (w_ch == CHW'(g)) & (w_fld == FLD_CTRL);
      assign w_wr_width[g] = w_wr & (w_ch == CHW'(g)) & (w_fld == FLD_WIDTH);

      servo_channel #(
        .DW (DW)
      ) u_ch (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wr_ctrl   (w_wr_ctrl[g]),
        .i_wr_width  (w_wr_width[g]),
        .i_d_in      (i_d_in),
        .i_copy      (w_copy[g]),
        .i_cnt       (r_cnt),
        .o_stg_ctrl  (w_stg_ctrl[g]),
        .o_stg_width (w_stg_width[g]),
        .o_status    (w_status[g]),
        .o_pwm       (o_pwm_out[g]),
        .o_dir       (o_dir_out[g])
      );
    end
  endgenerate

  // -------------------------------------------------------------- read mux
  always_comb begin
    w_rd_next = '0;
    if (w_ch_ok) begin
      case (w_fld)
        FLD_CTRL:   w_rd_next = {{(DW-2){1'b0}}, w_stg_ctrl[w_ch]};
        FLD_WIDTH:  w_rd_next = w_stg_width[w_ch];
        FLD_STATUS: w_rd_next = {{(DW-2){1'b0}}, w_status[w_ch]};
        default:    w_rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          r_rd_data <= '0;
    else if (i_cs & ~i_wr) r_rd_data <= w_rd_next;
  end

  assign o_rd_data      = r_rd_data;
  assign o_period_start = r_period_start;

endmodule
